// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the 16x8 sync RAM: gnt at T+1, rvalid at T+3, one access per 3 cycles.
// Requesters hold their command until gnt; ties use round-robin when RAM_ARB_RR_EN is defined, else requester 0 wins.
module ram_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       busy,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t state;
  logic   owner;
  logic   op_wr;
  logic   pick1;
`ifdef RAM_ARB_RR_EN
  logic   last_owner;
`endif

  always_comb begin
    pick1 = req1 & ~req0;
`ifdef RAM_ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    if (req0 && req1) pick1 = ~last_owner;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      op_wr    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= 8'h00;
      rdata1   <= 8'h00;
      busy     <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= 4'h0;
      ram_din  <= 8'h00;
`ifdef RAM_ARB_RR_EN
      last_owner <= 1'b1;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          if (req0 || req1) begin
            owner    <= pick1;
            op_wr    <= pick1 ? we1 : we0;
            ram_we   <= pick1 ? we1 : we0;
            ram_addr <= pick1 ? addr1 : addr0;
            ram_din  <= pick1 ? wdata1 : wdata0;
            gnt0     <= ~pick1;
            gnt1     <= pick1;
            busy     <= 1'b1;
            state    <= ACCESS;
`ifdef RAM_ARB_RR_EN
            last_owner <= pick1;
`endif
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          // Write transactions see the pre-write word here; it is dropped.
          if (!op_wr) begin
            if (owner) begin
              rdata1  <= ram_dout;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= ram_dout;
              rvalid0 <= 1'b1;
            end
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, queued requesters, transaction-level schedule model.
// Honours RAM_ARB_RR_EN the same way as the design.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       busy, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with registered read-before-write output.
  logic [7:0] ram_mem [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                               8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
  always @(posedge clk) begin
    ram_dout <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_din;
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t q0[$], q1[$];
  bit   pend0, pend1;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, next_idle = 0;
  int cnt_gnt0, cnt_rv1, gcount;
  logic [5:0] gseq;

  logic [7:0] mdl_mem [16];
  logic [7:0] x_rdata0, x_rdata1;
  int u_cyc = -1, u_addr = 0;
  logic [7:0] u_old;
`ifdef RAM_ARB_RR_EN
  bit m_last;
`endif

  // Expected outputs per future cycle, indexed by cycle mod 8.
  bit         e_gnt0[8], e_gnt1[8], e_busy[8], e_we[8], e_rv0[8], e_rv1[8], e_acc[8];
  logic [7:0] e_rd[8], e_addr[8], e_din[8];

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 8; i++) begin
      e_gnt0[i] = 0; e_gnt1[i] = 0; e_busy[i] = 0; e_we[i] = 0;
      e_rv0[i] = 0; e_rv1[i] = 0; e_acc[i] = 0;
      e_rd[i] = 0; e_addr[i] = 0; e_din[i] = 0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_rv"}, {rvalid1, rvalid0}, 0);
    chk({tag, "_rd0"}, rdata0, 0);
    chk({tag, "_rd1"}, rdata1, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_din"}, ram_din, 0);
  endtask

  // Called mid-cycle: compare against the schedule, then schedule from this cycle's inputs.
  task automatic model_step();
    int s, s1, s2, s3;
    bit w, cwe;
    logic [3:0] ca;
    logic [7:0] cd;
    s = cyc % 8;
    if (e_rv0[s]) x_rdata0 = e_rd[s];
    if (e_rv1[s]) x_rdata1 = e_rd[s];
    chk("gnt0", gnt0, e_gnt0[s]);
    chk("gnt1", gnt1, e_gnt1[s]);
    chk("busy", busy, e_busy[s]);
    chk("ram_we", ram_we, e_we[s]);
    chk("rvalid0", rvalid0, e_rv0[s]);
    chk("rvalid1", rvalid1, e_rv1[s]);
    chk("rdata0", rdata0, x_rdata0);
    chk("rdata1", rdata1, x_rdata1);
    if (e_acc[s]) begin
      chk("ram_addr", ram_addr, e_addr[s]);
      if (e_we[s]) chk("ram_din", ram_din, e_din[s]);
    end
    e_gnt0[s] = 0; e_gnt1[s] = 0; e_busy[s] = 0; e_we[s] = 0;
    e_rv0[s] = 0; e_rv1[s] = 0; e_acc[s] = 0;

    if (gnt0) begin
      cnt_gnt0++;
      if (gcount < 6) begin gseq[gcount] = 1'b0; gcount++; end
      pend0 = 0;
    end
    if (gnt1) begin
      if (gcount < 6) begin gseq[gcount] = 1'b1; gcount++; end
      pend1 = 0;
    end
    if (rvalid1) cnt_rv1++;

    if (cyc == next_idle) begin
      if (req0 || req1) begin
        w = req1 && !req0;
`ifdef RAM_ARB_RR_EN
        if (req0 && req1) w = !m_last;
        m_last = w;
`endif
        cwe = w ? we1 : we0;
        ca  = w ? addr1 : addr0;
        cd  = w ? wdata1 : wdata0;
        s1 = (cyc + 1) % 8; s2 = (cyc + 2) % 8; s3 = (cyc + 3) % 8;
        e_gnt0[s1] = !w; e_gnt1[s1] = w;
        e_busy[s1] = 1; e_busy[s2] = 1;
        e_we[s1] = cwe; e_acc[s1] = 1; e_addr[s1] = {4'h0, ca}; e_din[s1] = cd;
        if (!cwe) begin
          if (w) e_rv1[s3] = 1; else e_rv0[s3] = 1;
          e_rd[s3] = mdl_mem[ca];
        end else begin
          u_cyc = cyc + 1; u_addr = int'(ca); u_old = mdl_mem[ca];
          mdl_mem[ca] = cd;
        end
        next_idle = cyc + 3;
      end else begin
        next_idle = cyc + 1;
      end
    end
  endtask

  task automatic drive_reqs();
    cmd_t c;
    if (!pend0) begin
      if (q0.size() > 0) begin
        c = q0.pop_front();
        req0 = 1; we0 = c.we; addr0 = c.addr; wdata0 = c.data; pend0 = 1;
      end else req0 = 0;
    end
    if (!pend1) begin
      if (q1.size() > 0) begin
        c = q1.pop_front();
        req1 = 1; we1 = c.we; addr1 = c.addr; wdata1 = c.data; pend1 = 1;
      end else req1 = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_reqs();
    @(negedge clk);
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input bit r, input bit we, input int a, input int d);
    cmd_t c;
    c.we = we; c.addr = 4'(a); c.data = 8'(d);
    if (r) q1.push_back(c); else q0.push_back(c);
  endtask

  // Asserted mid-cycle, away from any clock edge.
  task automatic reset_apply();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    if (u_cyc >= cyc) mdl_mem[u_addr] = u_old;
    u_cyc = -1;
    clear_slots();
    x_rdata0 = 0; x_rdata1 = 0;
    q0.delete(); q1.delete();
    pend0 = 0; pend1 = 0;
    req0 = 0; req1 = 0;
`ifdef RAM_ARB_RR_EN
    m_last = 1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    next_idle = cyc;
    @(negedge clk);
    model_step();
  endtask

  initial begin
    logic [5:0] tie_exp;
    logic [7:0] exp5;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'(i * 17);
    cnt_gnt0 = 0; cnt_rv1 = 0; gcount = 0; gseq = 0;
    clear_slots();
    #2;
    reset_apply();

    // Write then read back from requester 0.
    push(0, 1, 3, 8'hA5);
    push(0, 0, 3, 0);
    run(9);
    chk("rd3", rdata0, 8'hA5);
    run(3);

    // Both requesters held high for six accesses from a fresh reset.
    reset_apply();
    gcount = 0; gseq = 0;
    for (int i = 0; i < 6; i++) begin
      push(0, 0, i, 0);
      push(1, 0, 8 + i, 0);
    end
    run(20);
`ifdef RAM_ARB_RR_EN
    tie_exp = 6'b101010;
`else
    tie_exp = 6'b000000;
`endif
    chk("tie_seq", gseq, tie_exp);
    chk("tie_cnt", gcount, 6);
    run(24);

    // Requester 1 writes addr 15, requester 0 reads it back.
    cnt_rv1 = 0;
    push(1, 1, 15, 8'h3C);
    run(3);
    push(0, 0, 15, 0);
    run(8);
    chk("rd15", rdata0, 8'h3C);
    chk("rv1_none", cnt_rv1, 0);

    // Back-to-back requests from requester 0.
    cnt_gnt0 = 0;
    push(0, 0, 1, 0); push(0, 0, 2, 0); push(0, 0, 4, 0);
    run(9);
    chk("b2b_gnt", cnt_gnt0, 3);
    run(3);

    // Reset during the access cycle of a write to addr 7.
    push(0, 1, 7, 8'h5A);
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        tick();
        if (gnt0) seen = 1;
      end
      chk("wait_gnt7", seen, 1);
    end
    reset_apply();
    run(2);
    push(0, 0, 7, 0);
    run(6);
    chk("rd7_after_rst", rdata0, 8'h77);

    // A write by requester 1 must leave rdata1 alone.
    push(1, 0, 5, 0);
    run(6);
    exp5 = mdl_mem[5];
    cnt_rv1 = 0;
    push(1, 1, 0, 8'hC3);
    run(6);
    chk("wr_no_rv1", cnt_rv1, 0);
    chk("rdata1_hold", rdata1, exp5);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if (q0.size() == 0 && $urandom_range(2) == 0)
        push(0, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(255));
      if (q1.size() == 0 && $urandom_range(2) == 0)
        push(1, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(255));
      tick();
    end
    run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
